power_trigger_ctrl: RTL

Configuration sequencer for the power trigger. A host writes new threshold, window and skip values into shadow registers. The block applies them atomically, but only while no packet is in progress; if a packet lasts too long, it applies them after a timeout. On each apply it drives the `num_sample_changed` request until the trigger's strobe-gated logic has sampled it. It also owns the trigger `enable` and counts detected packets for the host.

---
 rtl/power_trigger_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/power_trigger_ctrl.sv
// Trigger config sequencer: shadow regs applied atomically between packets (or after a timeout),
// then num_sample_changed is held until the enabled trigger samples it on a strobe.
module power_trigger_ctrl #(
  parameter logic [15:0] DEF_THRES  = 16'd100,
  parameter logic [15:0] DEF_WINDOW = 16'd80,
  parameter logic [31:0] DEF_SKIP   = 32'd0,
  parameter logic [23:0] TIMEOUT    = 24'd2000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cfg_wr_valid,
  output logic        cfg_wr_ready,
  input  logic [1:0]  cfg_wr_addr,
  input  logic [31:0] cfg_wr_data,
  input  logic        sample_in_strobe,
  input  logic        trigger,
  output logic [15:0] power_thres,
  output logic [15:0] window_size,
  output logic [31:0] num_sample_to_skip,
  output logic        num_sample_changed,
  output logic        enable,
  output logic        pending,
  output logic        forced,
  output logic [31:0] pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] thres_sh_q, thres_sh_d, win_sh_q, win_sh_d;
  logic [31:0] skip_sh_q, skip_sh_d;
  logic [15:0] thres_q, thres_d, win_q, win_d;
  logic [31:0] skip_q, skip_d;
  logic        nsc_q, nsc_d, en_q, en_d, pend_q, pend_d;
  logic        forced_q, forced_d, trig_q, trig_d;
  logic [31:0] pkt_q, pkt_d;
  logic [23:0] tmo_q, tmo_d;
  logic        wr_acc, ctl_wr;

  assign cfg_wr_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign wr_acc       = cfg_wr_valid && cfg_wr_ready;
  assign ctl_wr       = wr_acc && (cfg_wr_addr == 2'd3);

  always_comb begin
    state_d    = state_q;
    thres_sh_d = thres_sh_q;
    win_sh_d   = win_sh_q;
    skip_sh_d  = skip_sh_q;
    thres_d    = thres_q;
    win_d      = win_q;
    skip_d     = skip_q;
    nsc_d      = nsc_q;
    en_d       = en_q;
    pend_d     = pend_q;
    forced_d   = forced_q;
    trig_d     = trigger;
    pkt_d      = pkt_q;
    tmo_d      = tmo_q;

    if (wr_acc) begin
      case (cfg_wr_addr)
        2'd0:    thres_sh_d = cfg_wr_data[15:0];
        2'd1:    win_sh_d   = cfg_wr_data[15:0];
        2'd2:    skip_sh_d  = cfg_wr_data;
        default: en_d       = cfg_wr_data[0];
      endcase
    end else if (cfg_wr_valid && (cfg_wr_addr == 2'd3)) begin
      // Enable is observed even while a request is held, otherwise a commit
      // issued with enable=0 could never complete without a reset.
      en_d = cfg_wr_data[0];
    end

    if (trigger && !trig_q && (pkt_q != 32'hFFFF_FFFF)) pkt_d = pkt_q + 32'd1;
    if (ctl_wr && cfg_wr_data[2]) begin
      pkt_d    = '0;
      forced_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ctl_wr && cfg_wr_data[1]) begin
          state_d = S_WAIT;
          pend_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        if (!trigger) begin
          state_d = S_APPLY;
        end else if (tmo_q == TIMEOUT - 24'd1) begin
          forced_d = 1'b1;
          state_d  = S_APPLY;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_APPLY: begin
        thres_d = thres_sh_q;
        win_d   = win_sh_q;
        skip_d  = skip_sh_q;
        nsc_d   = 1'b1;
        state_d = S_HOLD;
      end
      default: begin
        if (sample_in_strobe && en_q) begin
          nsc_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      thres_sh_q <= DEF_THRES;
      win_sh_q   <= DEF_WINDOW;
      skip_sh_q  <= DEF_SKIP;
      thres_q    <= DEF_THRES;
      win_q      <= DEF_WINDOW;
      skip_q     <= DEF_SKIP;
      nsc_q      <= 1'b0;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      forced_q   <= 1'b0;
      trig_q     <= 1'b0;
      pkt_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      thres_sh_q <= thres_sh_d;
      win_sh_q   <= win_sh_d;
      skip_sh_q  <= skip_sh_d;
      thres_q    <= thres_d;
      win_q      <= win_d;
      skip_q     <= skip_d;
      nsc_q      <= nsc_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      forced_q   <= forced_d;
      trig_q     <= trig_d;
      pkt_q      <= pkt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign power_thres        = thres_q;
  assign window_size        = win_q;
  assign num_sample_to_skip = skip_q;
  assign num_sample_changed = nsc_q;
  assign enable             = en_q;
  assign pending            = pend_q;
  assign forced             = forced_q;
  assign pkt_count          = pkt_q;

endmodule
